gpio_debounce_enc: RTL and testbench

GPIO_DEBOUNCE_ENC -- requirements
Module: gpio_debounce_enc

---
 rtl/gpio_debounce_enc.sv | 204 ++++++++++++++++++++
 tb/tb_gpio_debounce_enc.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce_enc.sv
// Debounces N_IN active-high buttons, reports the lowest pressed key and emits
// press/release (plus optional auto-repeat) events through a one-deep handshake slot.
module gpio_debounce_enc #(
    parameter int unsigned N_IN          = 4,
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned DEB_SAMPLES   = 4,
    parameter int unsigned REPEAT_TICKS  = 250,
    localparam int unsigned CODE_W       = $clog2(N_IN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IN-1:0]   inuser,
    input  logic              repeat_en,
    input  logic              evt_ready,
    input  logic              clear,
    output logic [N_IN-1:0]   db_state,
    output logic [CODE_W-1:0] key_code,
    output logic              evt_valid,
    output logic [CODE_W-1:0] evt_code,
    output logic              evt_release,
    output logic              overflow
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DEB_W  = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;
    localparam int unsigned REP_W  = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    logic [N_IN-1:0]   sync_meta;
    logic [N_IN-1:0]   sync_q;

    logic [DEB_W-1:0]  deb_cnt [N_IN];
    logic [N_IN-1:0]   deb_accept;
    logic [N_IN-1:0]   rise;
    logic [N_IN-1:0]   fall;

    logic [CODE_W-1:0] key_prev;
    logic [REP_W-1:0]  rep_cnt;
    logic              rep_hold;
    logic              rep_fire;
    logic [N_IN-1:0]   rep_set;

    logic [N_IN-1:0]   press_pend;
    logic [N_IN-1:0]   rel_pend;
    logic [N_IN-1:0]   press_set;
    logic [N_IN-1:0]   rel_set;
    logic [N_IN-1:0]   press_served;
    logic [N_IN-1:0]   rel_served;
    logic              load;
    logic              sel_found;
    logic [CODE_W-1:0] sel_code;
    logic              sel_release;
    logic              ovf_c;

    // Free-running sample-tick divider
    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Two-flop synchronizer on the raw button levels
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= inuser;
            sync_q    <= sync_meta;
        end
    end

    // A change is accepted on the DEB_SAMPLES-th consecutive disagreeing tick
    always_comb begin
        deb_accept = '0;
        for (int i = 0; i < N_IN; i++) begin
            deb_accept[i] = tick && (sync_q[i] != db_state[i])
                            && (deb_cnt[i] == DEB_W'(DEB_SAMPLES - 1));
        end
    end

    assign rise = deb_accept & sync_q;
    assign fall = deb_accept & ~sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            db_state <= '0;
            for (int i = 0; i < N_IN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync_q[i] == db_state[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_accept[i]) begin
                    deb_cnt[i]  <= '0;
                    db_state[i] <= sync_q[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Lowest-index pressed button wins
    always_comb begin
        key_code = '0;
        for (int i = int'(N_IN) - 1; i >= 0; i--) begin
            if (db_state[i]) begin
                key_code = CODE_W'(i + 1);
            end
        end
    end

    // Auto-repeat: only counts while the same key stays down
    assign rep_hold = repeat_en && (key_code != '0) && (key_code == key_prev);
    assign rep_fire = rep_hold && tick && (rep_cnt == REP_W'(REPEAT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev <= '0;
            rep_cnt  <= '0;
        end else begin
            key_prev <= key_code;
            if (!rep_hold) begin
                rep_cnt <= '0;
            end else if (tick) begin
                rep_cnt <= rep_fire ? '0 : rep_cnt + REP_W'(1);
            end
        end
    end

    always_comb begin
        rep_set = '0;
        for (int i = 0; i < N_IN; i++) begin
            rep_set[i] = rep_fire && (key_code == CODE_W'(i + 1));
        end
    end

    assign press_set = rise | rep_set;
    assign rel_set   = fall;
    assign load      = !evt_valid || evt_ready;

    // Slot arbitration: lowest channel first, press before release
    always_comb begin
        sel_found    = 1'b0;
        sel_code     = '0;
        sel_release  = 1'b0;
        press_served = '0;
        rel_served   = '0;
        for (int i = int'(N_IN) - 1; i >= 0; i--) begin
            if (press_pend[i] || rel_pend[i]) begin
                sel_found   = 1'b1;
                sel_code    = CODE_W'(i + 1);
                sel_release = !press_pend[i];
            end
        end
        for (int i = 0; i < N_IN; i++) begin
            if (load && sel_found && (sel_code == CODE_W'(i + 1))) begin
                press_served[i] = press_pend[i];
                rel_served[i]   = !press_pend[i];
            end
        end
    end

    // Re-setting a flag that is still pending (and not being served) loses an event
    assign ovf_c = |((press_set & press_pend & ~press_served)
                   | (rel_set & rel_pend & ~rel_served));

    always_ff @(posedge clk) begin
        if (reset) begin
            press_pend <= '0;
            rel_pend   <= '0;
            overflow   <= 1'b0;
        end else begin
            press_pend <= (press_pend & ~press_served) | press_set;
            rel_pend   <= (rel_pend & ~rel_served) | rel_set;
            overflow   <= ovf_c || (overflow && !clear);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid   <= 1'b0;
            evt_code    <= '0;
            evt_release <= 1'b0;
        end else if (load) begin
            evt_valid <= sel_found;
            if (sel_found) begin
                evt_code    <= sel_code;
                evt_release <= sel_release;
            end
        end
    end

endmodule

// File: tb/tb_gpio_debounce_enc.sv
// Scoreboard bench for gpio_debounce_enc: expected events are queued as buttons
// are driven and popped by a monitor on every accepted handshake.
module tb_gpio_debounce_enc;

    localparam int unsigned N_IN   = 4;
    localparam int unsigned CODE_W = 3;

    logic              clk;
    logic              reset;
    logic [N_IN-1:0]   inuser;
    logic              repeat_en;
    logic              evt_ready;
    logic              clear;
    logic [N_IN-1:0]   db_state;
    logic [CODE_W-1:0] key_code;
    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;
    logic              evt_release;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    gpio_debounce_enc #(
        .N_IN(N_IN), .TICK_DIV(4), .DEB_SAMPLES(3), .REPEAT_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .inuser(inuser), .repeat_en(repeat_en),
        .evt_ready(evt_ready), .clear(clear), .db_state(db_state),
        .key_code(key_code), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_release(evt_release), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Pops one expected {release, code} per accepted event
    task automatic monitor();
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (!reset && evt_valid && evt_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL evt_unexpected: got code=%0d rel=%0d, required no event",
                             evt_code, evt_release);
                end else begin
                    e = exp_q.pop_front();
                    if ({evt_release, evt_code} !== e) begin
                        n_err++;
                        $display("FAIL evt_payload: got code=%0d rel=%0d, required code=%0d rel=%0d",
                                 evt_code, evt_release, e[2:0], e[3]);
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic [N_IN-1:0] v);
        @(posedge clk); #1;
        inuser = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_db(input logic [N_IN-1:0] v, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (db_state === v) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL %s: db_state=%b, required %b within 60 cycles", nm, db_state, v);
        end
    endtask

    task automatic check_drained(input string nm);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected events never seen, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; inuser = '0; repeat_en = 1'b0; evt_ready = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({db_state, key_code, evt_valid, evt_code, evt_release, overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_state: db=%b key=%0d v=%b code=%0d rel=%b ovf=%b, required all 0",
                     db_state, key_code, evt_valid, evt_code, evt_release, overflow);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_press();
        bit found = 1'b0;
        @(posedge clk); #1;
        evt_ready = 1'b1;
        drive(4'b0010);
        exp_q.push_back({1'b0, 3'd2});
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (db_state === 4'b0010) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL press_db: db_state=%b, required 0010", db_state);
        end else begin
            n_cmp++;
            if (key_code !== 3'd2) begin
                n_err++;
                $display("FAIL press_key: key_code=%0d, required 2", key_code);
            end
            n_cmp++;
            if (evt_valid !== 1'b0) begin
                n_err++;
                $display("FAIL press_latency0: evt_valid=%b on db change, required 0", evt_valid);
            end
            @(negedge clk);
            n_cmp++;
            if ({evt_valid, evt_release, evt_code} !== {1'b1, 1'b0, 3'd2}) begin
                n_err++;
                $display("FAIL press_latency1: v=%b rel=%b code=%0d, required 1 0 2",
                         evt_valid, evt_release, evt_code);
            end
        end
        drive(4'b0000);
        exp_q.push_back({1'b1, 3'd2});
        wait_db(4'b0000, "release_db");
        idle(4);
        check_drained("single_press_drain");
    endtask

    task automatic test_bounce();
        for (int t = 0; t < 8; t++) begin
            drive((t % 2 == 0) ? 4'b0001 : 4'b0000);
            repeat (5) begin
                @(negedge clk);
                n_cmp++;
                if (db_state !== 4'b0000 || evt_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL bounce: db_state=%b evt_valid=%b, required 0000 0",
                             db_state, evt_valid);
                end
            end
        end
        idle(12);
        check_drained("bounce_drain");
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        evt_ready = 1'b0;
        drive(4'b0101);
        exp_q.push_back({1'b0, 3'd1});
        exp_q.push_back({1'b0, 3'd3});
        wait_db(4'b0101, "bp_db");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({evt_valid, evt_release, evt_code} !== {1'b1, 1'b0, 3'd1}) begin
                n_err++;
                $display("FAIL bp_hold: v=%b rel=%b code=%0d, required 1 0 1",
                         evt_valid, evt_release, evt_code);
            end
        end
        @(posedge clk); #1; evt_ready = 1'b1;
        @(posedge clk); #1; evt_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({evt_valid, evt_release, evt_code} !== {1'b1, 1'b0, 3'd3}) begin
            n_err++;
            $display("FAIL bp_second: v=%b rel=%b code=%0d, required 1 0 3",
                     evt_valid, evt_release, evt_code);
        end
        @(posedge clk); #1; evt_ready = 1'b1;
        @(posedge clk); #1; evt_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_empty: evt_valid=%b, required 0", evt_valid);
        end
        @(posedge clk); #1; evt_ready = 1'b1;
        drive(4'b0000);
        exp_q.push_back({1'b1, 3'd1});
        exp_q.push_back({1'b1, 3'd3});
        wait_db(4'b0000, "bp_release_db");
        idle(4);
        check_drained("bp_drain");
    endtask

    task automatic test_overflow();
        @(posedge clk); #1;
        evt_ready = 1'b0;
        drive(4'b0010);
        exp_q.push_back({1'b0, 3'd2});
        wait_db(4'b0010, "ovf_hold_slot");
        drive(4'b0011);
        exp_q.push_back({1'b0, 3'd1});
        wait_db(4'b0011, "ovf_press1");
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_early1: overflow=%b, required 0", overflow);
        end
        drive(4'b0010);
        exp_q.push_back({1'b1, 3'd1});
        wait_db(4'b0010, "ovf_release");
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_early2: overflow=%b, required 0", overflow);
        end
        drive(4'b0011);
        wait_db(4'b0011, "ovf_press2");
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: overflow=%b, required 1", overflow);
        end
        idle(3);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: overflow=%b, required 1", overflow);
        end
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
        end
        @(posedge clk); #1; evt_ready = 1'b1;
        idle(6);
        check_drained("ovf_merge_drain");
        drive(4'b0000);
        exp_q.push_back({1'b1, 3'd1});
        exp_q.push_back({1'b1, 3'd2});
        wait_db(4'b0000, "ovf_release_all");
        idle(4);
        check_drained("ovf_drain");
    endtask

    task automatic test_repeat();
        int k = 0;
        int cyc = 0;
        int t[3];
        @(posedge clk); #1;
        repeat_en = 1'b1;
        evt_ready = 1'b1;
        drive(4'b1000);
        repeat (3) exp_q.push_back({1'b0, 3'd4});
        for (int i = 0; i < 80 && k < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (evt_valid) begin
                t[k] = cyc;
                k++;
            end
        end
        n_cmp++;
        if (k != 3) begin
            n_err++;
            $display("FAIL rep_count: saw %0d events, required 3", k);
        end else begin
            n_cmp++;
            if (t[1] - t[0] != 8) begin
                n_err++;
                $display("FAIL rep_interval1: %0d cycles, required 8", t[1] - t[0]);
            end
            n_cmp++;
            if (t[2] - t[1] != 8) begin
                n_err++;
                $display("FAIL rep_interval2: %0d cycles, required 8", t[2] - t[1]);
            end
        end
        // Release lands so that two more repeats precede the release event
        repeat (6) @(posedge clk);
        #1;
        inuser = 4'b0000;
        exp_q.push_back({1'b0, 3'd4});
        exp_q.push_back({1'b0, 3'd4});
        exp_q.push_back({1'b1, 3'd4});
        wait_db(4'b0000, "rep_release_db");
        idle(30);
        check_drained("rep_drain");
        @(posedge clk); #1;
        repeat_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(posedge clk); #1;
        evt_ready = 1'b0;
        drive(4'b0100);
        exp_q.push_back({1'b0, 3'd3});
        wait_db(4'b0100, "rm_db");
        @(negedge clk);
        n_cmp++;
        if ({evt_valid, evt_code} !== {1'b1, 3'd3}) begin
            n_err++;
            $display("FAIL rm_slot: v=%b code=%0d, required 1 3", evt_valid, evt_code);
        end
        drive(4'b0000);
        idle(5);
        @(posedge clk); #1; reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({db_state, key_code, evt_valid, evt_code, evt_release, overflow} !== '0) begin
            n_err++;
            $display("FAIL rm_outputs: db=%b key=%0d v=%b code=%0d rel=%b ovf=%b, required all 0",
                     db_state, key_code, evt_valid, evt_code, evt_release, overflow);
        end
        @(posedge clk); #1; evt_ready = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (evt_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL rm_stale: %0d cycles with evt_valid, required 0", seen);
        end
        check_drained("rm_drain");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_press();
        test_bounce();
        test_backpressure();
        test_overflow();
        test_repeat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
